// File: rtl/priority_arbiter_if.sv
// priority_arbiter_if: request/grant bundle between five requesters and the arbiter
interface priority_arbiter_if;
  logic req0, req1, req2, req3, req4;
  logic gnt0, gnt1, gnt2, gnt3, gnt4;
  modport master (output req0, req1, req2, req3, req4, input gnt0, gnt1, gnt2, gnt3, gnt4);
  modport slave  (input req0, req1, req2, req3, req4, output gnt0, gnt1, gnt2, gnt3, gnt4);
endinterface

// File: rtl/priority_arbiter.sv
// priority_arbiter: five-way fixed-priority arbiter with registered one-hot grants
// Define PRIORITY_ARBITER_LOCK_EN for non-preemptive (locking) grants.
module priority_arbiter (
  input  logic clock,
  input  logic reset,
  priority_arbiter_if.slave bus
);
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    G0   = 6'b000010,
    G1   = 6'b000100,
    G2   = 6'b001000,
    G3   = 6'b010000,
    G4   = 6'b100000
  } state_t;
  state_t state, win;
  logic [4:0] req;
  logic hold;
  assign req = {bus.req4, bus.req3, bus.req2, bus.req1, bus.req0};
  always_comb win = req[0] ? G0 : req[1] ? G1 : req[2] ? G2 : req[3] ? G3 : req[4] ? G4 : IDLE;
`ifdef PRIORITY_ARBITER_LOCK_EN
  // The current owner keeps the resource while its own request stays up.
  assign hold = |(state[5:1] & req);
`else
  assign hold = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= hold ? state : win;
  assign bus.gnt0 = state[1];
  assign bus.gnt1 = state[2];
  assign bus.gnt2 = state[3];
  assign bus.gnt3 = state[4];
  assign bus.gnt4 = state[5];
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: table vectors, directed sequences and random traffic against an owner-index model
module tb_priority_arbiter;
  logic clock = 1'b0;
  logic reset;
  priority_arbiter_if bus ();
  priority_arbiter dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int owner = -1;
  logic [4:0] g;
  assign g = {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};

  typedef struct {
    logic [4:0] v;
    logic [4:0] exp;
  } vec_t;
  vec_t tab [12];

  task automatic drive(input logic [4:0] v);
    {bus.req0, bus.req1, bus.req2, bus.req3, bus.req4} = v;
  endtask

  function automatic logic [4:0] reqs();
    return {bus.req4, bus.req3, bus.req2, bus.req1, bus.req0};
  endfunction

  function automatic void model();
    logic [4:0] r;
    r = reqs();
`ifdef PRIORITY_ARBITER_LOCK_EN
    if (owner >= 0 && r[owner]) return;
`endif
    owner = -1;
    for (int i = 4; i >= 0; i--) if (r[i]) owner = i;
  endfunction

  function automatic logic [4:0] mexp();
    return owner < 0 ? 5'b0 : 5'(1 << owner);
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    vectors++;
    if (g !== exp) begin
      miscompares++;
      $display("FAIL %s: gnt4..0=%b expected %b (t=%0t)", name, g, exp, $time);
    end
    vectors++;
    if ($countones(g) > 1 || $isunknown(g)) begin
      miscompares++;
      $display("FAIL %s_onehot: gnt4..0=%b expected one-hot or zero", name, g);
    end
  endtask

  task automatic cyc_exp(input logic [4:0] v, input string name, input logic [4:0] exp);
    drive(v);
    @(posedge clock);
    model();
    @(negedge clock);
    check(name, exp);
  endtask

  task automatic cyc(input logic [4:0] v, input string name);
    drive(v);
    @(posedge clock);
    model();
    @(negedge clock);
    check(name, mexp());
  endtask

  initial begin
    logic [4:0] v;
    tab[0]  = '{5'b00110, 5'b00100};
    tab[1]  = '{5'b10000, 5'b00001};
    tab[2]  = '{5'b01000, 5'b00010};
    tab[3]  = '{5'b00100, 5'b00100};
    tab[4]  = '{5'b00010, 5'b01000};
    tab[5]  = '{5'b00001, 5'b10000};
    tab[6]  = '{5'b11111, 5'b00001};
    tab[7]  = '{5'b00011, 5'b01000};
    tab[8]  = '{5'b01001, 5'b00010};
    tab[9]  = '{5'b00000, 5'b00000};
    tab[10] = '{5'b00101, 5'b00100};
    tab[11] = '{5'b01111, 5'b00010};

    reset = 1'b1;
    drive(5'b11111);
    repeat (2) begin
      @(negedge clock);
      check("reset_hold", 5'b00000);
    end
    #2 reset = 1'b0;
    owner = -1;
    cyc_exp(5'b11111, "reset_release", 5'b00001);

    for (int i = 0; i < 12; i++) begin
      cyc_exp(5'b00000, "table_idle", 5'b00000);
      cyc_exp(tab[i].v, "table", tab[i].exp);
    end

    for (int i = 0; i < 32; i++) cyc(5'(i), "sweep");

    repeat (5) cyc_exp(5'b00000, "idle", 5'b00000);
    cyc_exp(5'b00110, "idle_exit", 5'b00100);

    cyc_exp(5'b00000, "idle", 5'b00000);
`ifdef PRIORITY_ARBITER_LOCK_EN
    cyc_exp(5'b00010, "lock_req3", 5'b01000);
    cyc_exp(5'b10010, "lock_hold", 5'b01000);
    cyc_exp(5'b10000, "lock_pass", 5'b00001);
`else
    cyc_exp(5'b00001, "pre_req4", 5'b10000);
    cyc_exp(5'b01001, "preempt", 5'b00010);
    cyc_exp(5'b00001, "preempt_drop", 5'b10000);
`endif

    cyc_exp(5'b00000, "idle", 5'b00000);
    cyc_exp(5'b00110, "async_pre", 5'b00100);
    #2 reset = 1'b1;
    #1 check("async_reset", 5'b00000);
    owner = -1;
    #1 reset = 1'b0;
    #0 check("async_reset_low", 5'b00000);
    cyc_exp(5'b00110, "async_release", 5'b00100);

    v = 5'b0;
    repeat (400) begin
      if ($urandom_range(0, 1) == 0) v = 5'($urandom_range(0, 31));
      cyc(v, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Five-requester fixed-priority arbiter with registered, one-hot grants. It sits in front of a shared resource, such as a bus or memory port, and decides each cycle which requester owns it. Requester 0 has the highest priority and requester 4 the lowest. Grants are flops, so they are glitch-free and appear one clock after the requests that caused them.

## Interface
- Parameters: none. The requester count is fixed at 5.
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- req0  input  1  request from requester 0 (highest priority).
- req1  input  1  request from requester 1.
- req2  input  1  request from requester 2.
- req3  input  1  request from requester 3.
- req4  input  1  request from requester 4 (lowest priority).
- gnt0..gnt4  output  1 each  registered grant to the matching requester; at most one is high.

## Operation
- Requests are level-sensitive.
  - A requester holds reqN high for as long as it wants the resource.
  - No acknowledge handshake exists beyond gntN.
- Each rising clock edge (not in reset), the grant register loads the one-hot winner of the current requests:
  - gnt0 = req0
  - gnt1 = req1 and not req0
  - gnt2 = req2 and not (req0 or req1)
  - gnt3 = req3 and not (req0 or req1 or req2)
  - gnt4 = req4 and not (req0 or req1 or req2 or req3)
- No request asserted: all grants low on the next edge (idle, no parking).
- Preemption (default build):
  - A higher-priority request arriving while a lower one is granted takes the grant on the next edge.
  - The lower grant drops in that same edge.
- Starvation of low-priority requesters under continuous high-priority traffic is accepted behaviour.
- Invariant: at most one of gnt0..gnt4 is high in any cycle, including immediately after reset.
- Internal state is implemented as a small FSM.
  - States: IDLE, G0, G1, G2, G3, G4.
  - State is one-hot-encoded; outputs decode directly from the state.

## Timing
- Latency: requests sampled at edge k produce grants valid from edge k to edge k+1.
  - This is one cycle of latency, and request-to-grant is combinationally isolated.
- Deassertion: reqN dropping at edge k makes gntN low after edge k.
  - The resource is freed, or passed to the next winner, in the same edge.
- Reset:
  - Asserting reset forces all gnt outputs to 0 and the state to IDLE immediately, without waiting for a clock.
  - Reset asserted mid-grant drops the grant asynchronously.
  - While reset is high, requests are ignored.
- Reset release: the first rising edge after reset deasserts samples requests normally. No extra dead cycle.
- Simultaneous requests: resolved purely by index, lower index wins.
- Inputs must meet setup/hold to clock. No internal synchronisers.

## Configuration
- Macro: PRIORITY_ARBITER_LOCK_EN.
- Undefined (default): fully preemptive fixed priority, as described in Operation.
- Defined: non-preemptive (locking) behaviour.
  - Once gntN is high, it is held while reqN stays high, even if a higher-priority request arrives.
  - When reqN drops, the next edge grants the highest-priority pending request, or goes to IDLE.
  - Arbitration from IDLE and the reset behaviour are unchanged.

## Test plan
- Reset: hold reset high for 2 cycles with all requests at 1, then deassert mid-cycle -> all gnt0..gnt4 = 0 during reset.
  - First edge after release gives gnt0 = 1.
- Exhaustive sweep: drive {req0,req1,req2,req3,req4} = 0..31, one value per cycle (req0 as MSB).
  - After each edge, exactly one grant matches the highest-priority asserted request.
  - Example: 5'b00110 -> gnt2 = 1, others 0.
  - Value 0 -> all grants 0.
- Idle: drop all requests for 5 cycles after the sweep -> all grants 0 throughout, then 5'b00110 -> gnt2 = 1 on the next edge.
- Preemption (default build): req4 held, gnt4 = 1; raise req1 -> gnt1 = 1 and gnt4 = 0 after one edge.
  - Drop req1 -> gnt4 = 1 again on the next edge.
- Lock (PRIORITY_ARBITER_LOCK_EN defined): req3 granted, then raise req0 -> gnt3 stays 1.
  - Drop req3 -> gnt0 = 1 on the next edge.
- Async reset mid-grant: gnt2 = 1, pulse reset between clock edges -> gnt2 falls before the next rising edge.
  - Every cycle of every test checks the one-hot-or-zero grant invariant.
